onion_rgb_fader: RTL

Duty-cycle sequencer that sits directly upstream of the three per-channel ONION_PWM instances in the LED top level. It accepts a target RGB colour through a valid/ready handshake. It then ramps its registered red/green/blue duty-cycle outputs linearly toward that target, one LSB per channel per programmable step interval. It replaces hard-switched colour levels with smooth fades and signals completion so a higher-level colour sequencer can issue the next target.

---
 rtl/onion_rgb_fader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/onion_rgb_fader.sv
// Linear RGB duty-cycle fader: accepts a target colour by valid/ready and ramps
// each channel one LSB per step interval toward it, pulsing done on arrival.
module onion_rgb_fader #(
  parameter int PWM_RESOLUTION_BITS = 8,
  parameter int STEP_DIV_BITS       = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [STEP_DIV_BITS-1:0]       step_div,
  input  logic                           tgt_valid,
  output logic                           tgt_ready,
  input  logic [PWM_RESOLUTION_BITS-1:0] tgt_red,
  input  logic [PWM_RESOLUTION_BITS-1:0] tgt_green,
  input  logic [PWM_RESOLUTION_BITS-1:0] tgt_blue,
  output logic [PWM_RESOLUTION_BITS-1:0] red_val,
  output logic [PWM_RESOLUTION_BITS-1:0] green_val,
  output logic [PWM_RESOLUTION_BITS-1:0] blue_val,
  output logic                           busy,
  output logic                           done
);

  localparam logic [PWM_RESOLUTION_BITS-1:0] DUTY_ONE = 1;
  localparam logic [STEP_DIV_BITS-1:0]       PRE_ONE  = 1;

  typedef enum logic {IDLE, RAMP} state_t;

  state_t                           state, state_nx;
  logic [PWM_RESOLUTION_BITS-1:0]   red_nx, green_nx, blue_nx;
  logic [PWM_RESOLUTION_BITS-1:0]   red_tgt, green_tgt, blue_tgt;
  logic [PWM_RESOLUTION_BITS-1:0]   red_tgt_nx, green_tgt_nx, blue_tgt_nx;
  logic [STEP_DIV_BITS-1:0]         div_cap, div_cap_nx;
  logic [STEP_DIV_BITS-1:0]         presc, presc_nx;
  logic                             ready_nx, busy_nx, done_nx;

  // Moving strictly toward a target in range can never leave 0..2^W-1.
  function automatic logic [PWM_RESOLUTION_BITS-1:0] step_toward(
    input logic [PWM_RESOLUTION_BITS-1:0] cur,
    input logic [PWM_RESOLUTION_BITS-1:0] tgt
  );
    if (cur < tgt)      return cur + DUTY_ONE;
    else if (cur > tgt) return cur - DUTY_ONE;
    else                return cur;
  endfunction

  always_comb begin
    state_nx     = state;
    red_nx       = red_val;
    green_nx     = green_val;
    blue_nx      = blue_val;
    red_tgt_nx   = red_tgt;
    green_tgt_nx = green_tgt;
    blue_tgt_nx  = blue_tgt;
    div_cap_nx   = div_cap;
    presc_nx     = presc;
    ready_nx     = tgt_ready;
    busy_nx      = busy;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (tgt_valid && tgt_ready) begin
          red_tgt_nx   = tgt_red;
          green_tgt_nx = tgt_green;
          blue_tgt_nx  = tgt_blue;
          div_cap_nx   = step_div;
          presc_nx     = '0;
          ready_nx     = 1'b0;
          busy_nx      = 1'b1;
          state_nx     = RAMP;
        end
      end
      RAMP: begin
        if (presc == div_cap) begin
          presc_nx = '0;
          red_nx   = step_toward(red_val, red_tgt);
          green_nx = step_toward(green_val, green_tgt);
          blue_nx  = step_toward(blue_val, blue_tgt);
          // Completion is judged on post-step values so done lands on the final step edge.
          if (red_nx == red_tgt && green_nx == green_tgt && blue_nx == blue_tgt) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            ready_nx = 1'b1;
            done_nx  = 1'b1;
          end
        end else begin
          presc_nx = presc + PRE_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      red_val   <= '0;
      green_val <= '0;
      blue_val  <= '0;
      red_tgt   <= '0;
      green_tgt <= '0;
      blue_tgt  <= '0;
      div_cap   <= '0;
      presc     <= '0;
      tgt_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      red_val   <= red_nx;
      green_val <= green_nx;
      blue_val  <= blue_nx;
      red_tgt   <= red_tgt_nx;
      green_tgt <= green_tgt_nx;
      blue_tgt  <= blue_tgt_nx;
      div_cap   <= div_cap_nx;
      presc     <= presc_nx;
      tgt_ready <= ready_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule
